rr_priority_arbiter: RTL and testbench

//  Parametrised registered arbiter; successor to the combinational MSB-first priority encoder.

---
 rtl/rr_priority_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_priority_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// Registered request arbiter: fixed MSB-first or rotating round-robin selection,
// holding a one-hot plus binary grant under a valid/ready handshake.
module rr_priority_arbiter #(
   parameter int NUM_REQ = 8,
   localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               rr_en,
   input  logic               gnt_ready,
   output logic               gnt_valid,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [ID_W-1:0]    gnt_id
);

   // A zero-requester arbiter is meaningless; stop at elaboration.
   if (NUM_REQ < 1) begin : g_bad_num_req
      $fatal(1, "rr_priority_arbiter: NUM_REQ must be >= 1");
   end

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   onehot_q, onehot_d;
   logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
   logic [ID_W-1:0]      last_id_q, last_id_d;

   logic                 accept;
   logic                 load;
   logic                 any_req;
   logic [ID_W-1:0]      win_id;

   assign accept = (state_q == S_GRANT) && gnt_ready;
   assign load   = (state_q == S_IDLE) || gnt_ready;

   // Winner search: walk downward from the reference index, wrapping at NUM_REQ.
   // Fixed mode uses reference 0, which gives a plain MSB-first scan. On an accept
   // edge the reference is the grant being accepted, i.e. the new last_id.
   always_comb begin
      int              base_i;
      int              idx_i;
      logic [ID_W-1:0] idx_v;
      base_i  = 0;
      idx_i   = 0;
      idx_v   = '0;
      win_id  = '0;
      any_req = |req;
      if (rr_en) begin
         base_i = accept ? int'(gnt_id_q) : int'(last_id_q);
      end
      // Iterate farthest-first so the nearest set bit is the last one written.
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx_i = base_i - k;
         if (idx_i < 0) begin
            idx_i = idx_i + NUM_REQ;
         end
         idx_v = ID_W'(idx_i);
         if (req[idx_v]) begin
            win_id = idx_v;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: re-evaluate only at load edges; otherwise hold the grant.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = any_req ? S_GRANT : S_IDLE;
      end
   end

   // Grant payload and round-robin pointer for the next cycle.
   always_comb begin
      gnt_id_d  = gnt_id_q;
      onehot_d  = onehot_q;
      last_id_d = last_id_q;
      if (accept) begin
         last_id_d = gnt_id_q;
      end
      if (load) begin
         gnt_id_d = '0;
         onehot_d = '0;
         if (any_req) begin
            gnt_id_d         = win_id;
            onehot_d[win_id] = 1'b1;
         end
      end
   end

   // Grant payload registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_id_q  <= '0;
         onehot_q  <= '0;
         last_id_q <= '0;
      end else begin
         gnt_id_q  <= gnt_id_d;
         onehot_q  <= onehot_d;
         last_id_q <= last_id_d;
      end
   end

   assign gnt_valid  = (state_q == S_GRANT);
   assign gnt_onehot = onehot_q;
   assign gnt_id     = gnt_id_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench for rr_priority_arbiter at NUM_REQ = 8, 1 and 5.
module tb_rr_priority_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rr_en;
   logic       gnt_ready;
   logic [7:0] req8;
   logic [0:0] req1;
   logic [4:0] req5;

   logic       v8, v1, v5;
   logic [7:0] oh8;
   logic [0:0] oh1;
   logic [4:0] oh5;
   logic [2:0] id8;
   logic [0:0] id1;
   logic [2:0] id5;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state per DUT (0: N=8, 1: N=1, 2: N=5).
   int m_v[3];
   int m_id[3];
   int m_last[3];
   int cur_req, cur_rr, cur_rdy;

   rr_priority_arbiter #(.NUM_REQ(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .req(req8), .rr_en(rr_en), .gnt_ready(gnt_ready),
      .gnt_valid(v8), .gnt_onehot(oh8), .gnt_id(id8));
   rr_priority_arbiter #(.NUM_REQ(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req1), .rr_en(rr_en), .gnt_ready(gnt_ready),
      .gnt_valid(v1), .gnt_onehot(oh1), .gnt_id(id1));
   rr_priority_arbiter #(.NUM_REQ(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .req(req5), .rr_en(rr_en), .gnt_ready(gnt_ready),
      .gnt_valid(v5), .gnt_onehot(oh5), .gnt_id(id5));

   always #5 clk = ~clk;

   function automatic int nof(int d);
      return (d == 0) ? 8 : ((d == 1) ? 1 : 5);
   endfunction

   // Highest set index among the low n bits.
   function automatic int msb_idx(int r, int n);
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
      return 0;
   endfunction

   // First set bit in the order last-1, last-2, ... wrapping modulo n.
   function automatic int rr_pick(int r, int last, int n);
      for (int k = 1; k <= n; k++) begin
         int i;
         i = (last - k + n) % n;
         if (r[i]) return i;
      end
      return 0;
   endfunction

   task automatic check(string tag, int obs, int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_v[d] = 0; m_id[d] = 0; m_last[d] = 0;
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 3; d++) begin
         int n, r;
         n = nof(d);
         r = cur_req & ((1 << n) - 1);
         if (m_v[d] != 0 && cur_rdy != 0) m_last[d] = m_id[d];
         if (m_v[d] == 0 || cur_rdy != 0) begin
            if (r == 0) begin
               m_v[d] = 0; m_id[d] = 0;
            end else begin
               m_v[d]  = 1;
               m_id[d] = (cur_rr != 0) ? rr_pick(r, m_last[d], n) : msb_idx(r, n);
            end
         end
      end
   endtask

   task automatic check_all(string tag);
      for (int d = 0; d < 3; d++) begin
         int ov, oi, oo, eo;
         case (d)
            0:       begin ov = int'(v8); oi = int'(id8); oo = int'(oh8); end
            1:       begin ov = int'(v1); oi = int'(id1); oo = int'(oh1); end
            default: begin ov = int'(v5); oi = int'(id5); oo = int'(oh5); end
         endcase
         eo = (m_v[d] != 0) ? (1 << m_id[d]) : 0;
         check($sformatf("%s_n%0d_valid", tag, nof(d)), ov, m_v[d]);
         check($sformatf("%s_n%0d_id", tag, nof(d)), oi, m_id[d]);
         check($sformatf("%s_n%0d_onehot", tag, nof(d)), oo, eo);
      end
   endtask

   task automatic drive(int r, int rr, int rdy);
      cur_req = r; cur_rr = rr; cur_rdy = rdy;
      req8 = 8'(r); req1 = 1'(r); req5 = 5'(r);
      rr_en = 1'(rr); gnt_ready = 1'(rdy);
   endtask

   // Advance one rising edge, step the model, then sample 1 time unit later.
   task automatic tick(string tag);
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      #1;
      check_all(tag);
   endtask

   // Reset pulse between edges (called just after a rising edge).
   task automatic async_reset(string tag);
      #3 rst_n = 1'b0;
      #1 model_reset();
      check_all(tag);
      #1 rst_n = 1'b1;
   endtask

   int seq3[6] = '{7, 5, 2, 7, 5, 2};

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0);
      model_reset();

      // 1: held reset with random inputs.
      for (int i = 0; i < 5; i++) begin
         drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
         tick("t1_reset");
      end
      rst_n = 1'b1;

      // 2: fixed priority, A4 held, always ready.
      drive(8'hA4, 0, 1);
      for (int i = 0; i < 4; i++) begin
         tick("t2_fixed");
         check("t2_id_const", int'(id8), 7);
         check("t2_onehot_const", int'(oh8), 8'h80);
      end

      // 3: round-robin rotation from a fresh reset.
      async_reset("t3_rst");
      drive(8'hA4, 1, 1);
      for (int i = 0; i < 6; i++) begin
         tick("t3_rr");
         check("t3_seq", int'(id8), seq3[i]);
      end

      // 4: sticky grant, then switch request and drain.
      async_reset("t4_rst");
      drive(8'hA4, 1, 0);
      tick("t4_first");
      for (int i = 0; i < 3; i++) begin
         tick("t4_hold");
         check("t4_hold_id", int'(id8), 7);
      end
      drive(8'h01, 1, 1);
      tick("t4_switch");
      check("t4_switch_id", int'(id8), 0);
      drive(0, 1, 1);
      tick("t4_drain");
      check("t4_drain_valid", int'(v8), 0);

      // 5: reset in the middle of a held grant.
      async_reset("t5_rst0");
      drive(8'hA4, 1, 1);
      tick("t5_a");
      tick("t5_b");
      drive(8'hA4, 1, 0);
      tick("t5_hold");
      check("t5_hold_id", int'(id8), 5);
      async_reset("t5_midrst");
      check("t5_midrst_valid", int'(v8), 0);
      drive(8'h24, 1, 1);
      tick("t5_restart");
      check("t5_restart_id", int'(id8), 5);

      // 6: fixed-priority sweep over every request pattern.
      async_reset("t6_rst");
      for (int r = 0; r < 256; r++) begin
         drive(r, 0, 1);
         tick("t6_sweep");
      end

      // Random mix of modes, back-pressure, sticky holds and resets.
      for (int i = 0; i < 400; i++) begin
         drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
               ($urandom_range(0, 3) != 0) ? 1 : 0);
         tick("rnd");
         if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
